// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the byte-wide SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } spi_state_t;

  localparam int unsigned BITW       = 3;
  localparam int unsigned BYTEW      = 8;
  localparam int unsigned CLKDIV_MAX = 15;

  // Width of the half-period counter for a given SCK divider.
  function automatic int unsigned cnt_width(input int unsigned clkdiv);
    return $clog2(clkdiv + 1);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Register-side strobes plus SPI pins of the SPI master, grouped as one bundle.
interface spi_master_if #(
  parameter int unsigned NSS = 2
);

  logic           CSR_WE;
  logic [7:0]     CSR_DIN;
  logic           DATA_WE;
  logic [7:0]     DATA_DIN;
  logic [7:0]     DATA_DOUT;
  logic           BUSY;
  logic           OVR;
  logic           MISO;
  logic           MOSI;
  logic           SCK;
  logic [NSS-1:0] nSS;

  modport master (
    input  CSR_WE, CSR_DIN, DATA_WE, DATA_DIN, MISO,
    output DATA_DOUT, BUSY, OVR, MOSI, SCK, nSS
  );

  modport slave (
    output CSR_WE, CSR_DIN, DATA_WE, DATA_DIN, MISO,
    input  DATA_DOUT, BUSY, OVR, MOSI, SCK, nSS
  );

endinterface

// File: rtl/spi_halfper_cnt.sv
// SCK half-period counter: counts 0..CLKDIV-1 and flags the last cycle.
module spi_halfper_cnt
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = 2,
  parameter int unsigned CNTW   = cnt_width(CLKDIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  logic [CNTW-1:0] cnt_q, cnt_d;

  assign tick_c = (cnt_q == CNTW'(CLKDIV - 1));

  // Wrap on the last cycle of a half-period, hold at zero while cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick_c) cnt_d = '0;
    else               cnt_d = cnt_q + CNTW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// Byte-wide mode-0 SPI master: drives SCK/MOSI/nSS, samples pre-muxed MISO.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKDIV = 2,
  parameter int unsigned NSS    = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  spi_master_if.master bus
);

  localparam int unsigned CNTW = cnt_width(CLKDIV);

  spi_state_t           state_q, state_d;
  logic [BYTEW-1:0]     shreg_q, shreg_d;
  logic [BITW-1:0]      bitcnt_q, bitcnt_d;
  logic [BYTEW-1:0]     dout_q, dout_d;
  logic [NSS-1:0]       nss_q, nss_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;
  logic                 tick_c;
  logic                 unused_csr_bits;

  assign unused_csr_bits = ^bus.CSR_DIN;

  spi_halfper_cnt #(
    .CLKDIV (CLKDIV),
    .CNTW   (CNTW)
  ) u_halfper_cnt (
    .clk    (CLK),
    .rst_n  (nRST),
    .clr    (state_q == IDLE),
    .tick_c (tick_c)
  );

  // Next-state, shift register, register-side writes and pin outputs.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    dout_d   = dout_q;
    nss_d    = nss_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    ovr_d    = ovr_q;

    // Control register: only honoured while idle; OVR set beats OVR clear.
    if (bus.CSR_WE && !busy_q) begin
      nss_d = bus.CSR_DIN[NSS-1:0];
      if (bus.CSR_DIN[7]) ovr_d = 1'b0;
    end
    if ((bus.CSR_WE || bus.DATA_WE) && busy_q) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.DATA_WE) begin
          shreg_d  = bus.DATA_DIN;
          mosi_d   = bus.DATA_DIN[7];
          bitcnt_d = '0;
          busy_d   = 1'b1;
          state_d  = LO;
        end
      end
      LO: begin
        if (tick_c) begin
          sck_d   = 1'b1;
          shreg_d = {shreg_q[BYTEW-2:0], bus.MISO};
          state_d = HI;
        end
      end
      HI: begin
        if (tick_c) begin
          sck_d = 1'b0;
          if (bitcnt_q == BITW'(7)) begin
            dout_d  = shreg_q;
            busy_d  = 1'b0;
            mosi_d  = 1'b0;
            state_d = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + BITW'(1);
            mosi_d   = shreg_q[BYTEW-1];
            state_d  = LO;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      dout_q   <= '0;
      nss_q    <= '1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      dout_q   <= dout_d;
      nss_q    <= nss_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.SCK       = sck_q;
  assign bus.MOSI      = mosi_q;
  assign bus.nSS       = nss_q;
  assign bus.DATA_DOUT = dout_q;
  assign bus.BUSY      = busy_q;
  assign bus.OVR       = ovr_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: CLKDIV=2 and CLKDIV=1 instances, slave model, scoreboard.
module tb_spi_master;

  localparam int unsigned NSS = 2;
  localparam int ACT_NONE  = 0;
  localparam int ACT_RESET = 1;
  localparam int ACT_OVR   = 2;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         busy_cyc;
  } exp_t;

  typedef struct packed {
    logic           sck;
    logic           mosi;
    logic [NSS-1:0] nss;
    logic           busy;
    logic           ovr;
    logic [7:0]     dout;
  } snap_t;

  localparam snap_t RESET_SNAP = '{sck: 1'b0, mosi: 1'b0, nss: 2'b11, busy: 1'b0, ovr: 1'b0, dout: 8'h00};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       csr_we = 1'b0;
  logic       data_we = 1'b0;
  logic       miso = 1'b0;
  logic [7:0] csr_din = 8'h00;
  logic [7:0] data_din = 8'h00;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  spi_master_if #(.NSS(NSS)) b2();
  spi_master_if #(.NSS(NSS)) b1();

  spi_master #(.CLKDIV(2), .NSS(NSS)) u_dut_div2 (.CLK(clk), .nRST(rst_n), .bus(b2));
  spi_master #(.CLKDIV(1), .NSS(NSS)) u_dut_div1 (.CLK(clk), .nRST(rst_n), .bus(b1));

  assign b2.CSR_WE   = csr_we & ~sel;
  assign b1.CSR_WE   = csr_we & sel;
  assign b2.DATA_WE  = data_we & ~sel;
  assign b1.DATA_WE  = data_we & sel;
  assign b2.CSR_DIN  = csr_din;
  assign b1.CSR_DIN  = csr_din;
  assign b2.DATA_DIN = data_din;
  assign b1.DATA_DIN = data_din;
  assign b2.MISO     = miso;
  assign b1.MISO     = miso;

  logic           o_sck, o_mosi, o_busy, o_ovr;
  logic [7:0]     o_dout;
  logic [NSS-1:0] o_nss;

  assign o_sck  = sel ? b1.SCK       : b2.SCK;
  assign o_mosi = sel ? b1.MOSI      : b2.MOSI;
  assign o_busy = sel ? b1.BUSY      : b2.BUSY;
  assign o_ovr  = sel ? b1.OVR       : b2.OVR;
  assign o_dout = sel ? b1.DATA_DOUT : b2.DATA_DOUT;
  assign o_nss  = sel ? b1.nSS       : b2.nSS;

  function automatic snap_t take_snap();
    snap_t s;
    s.sck = o_sck; s.mosi = o_mosi; s.nss = o_nss;
    s.busy = o_busy; s.ovr = o_ovr; s.dout = o_dout;
    return s;
  endfunction

  // Control register write; returns on the negedge after the write edge.
  task automatic csr_write(input logic [7:0] v);
    csr_we = 1'b1; csr_din = v;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  // One transfer with a mode-0 slave model; called and returns on a negedge.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] slave, input int div,
                          input int action, output logic [7:0] mosi_cap,
                          output logic [7:0] dout, output int busy_cyc,
                          output int setup, output int period,
                          output bit aborted, output snap_t snap);
    int   cyc, rises, first_rise, second_rise;
    logic sck_prev;
    exp_t e;
    e.tx = tx; e.rx = slave; e.busy_cyc = 16 * div;
    sb_q.push_back(e);
    data_we = 1'b1; data_din = tx; miso = slave[7];
    mosi_cap = '0; busy_cyc = 0; rises = 0; first_rise = 0; second_rise = 0;
    aborted = 1'b0; sck_prev = 1'b0; snap = '0;
    @(negedge clk);
    data_we = 1'b0;
    cyc = 1;
    while (o_busy && cyc < 40 * div + 10) begin
      busy_cyc++;
      csr_we = 1'b0; data_we = 1'b0;
      if (o_sck && !sck_prev) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], o_mosi};
        if (rises == 1) first_rise = cyc;
        if (rises == 2) second_rise = cyc;
        if (rises < 8) miso = slave[3'(7 - rises)];
        if (rises == 4 && action == ACT_RESET) begin
          rst_n = 1'b0;
          #1;
          snap = take_snap();
          aborted = 1'b1;
          break;
        end
        if (rises == 4 && action == ACT_OVR) begin
          data_we = 1'b1; data_din = 8'h11; csr_we = 1'b1; csr_din = 8'h03;
        end
      end
      sck_prev = o_sck;
      @(negedge clk);
      cyc++;
    end
    csr_we = 1'b0; data_we = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL busy_timeout busy=%b after %0d cycles", o_busy, cyc);
    end
    dout = o_dout;
    setup = first_rise - 1;
    period = second_rise - first_rise;
  endtask

  task automatic test_reset();
    snap_t s;
    repeat (3) @(negedge clk);
    sel = 1'b0; s = take_snap();
    checks++; if (s !== RESET_SNAP) begin errors++; $display("FAIL reset_div2 got %h exp %h", s, RESET_SNAP); end
    sel = 1'b1; s = take_snap();
    checks++; if (s !== RESET_SNAP) begin errors++; $display("FAIL reset_div1 got %h exp %h", s, RESET_SNAP); end
    sel = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] mc, dout; int bc, su, per; bit ab; snap_t sn; exp_t e;
    sel = 1'b0;
    csr_write(8'h02);
    checks++; if (o_nss !== 2'b10) begin errors++; $display("FAIL basic_nss got %b exp 10", o_nss); end
    run_xfer(8'hA5, 8'h3C, 2, ACT_NONE, mc, dout, bc, su, per, ab, sn);
    e = sb_q.pop_front();
    checks++; if (mc !== e.tx) begin errors++; $display("FAIL basic_mosi got %h exp %h", mc, e.tx); end
    checks++; if (dout !== e.rx) begin errors++; $display("FAIL basic_dout got %h exp %h", dout, e.rx); end
    checks++; if (bc !== e.busy_cyc) begin errors++; $display("FAIL basic_busy_len got %0d exp %0d", bc, e.busy_cyc); end
    checks++; if (su !== 2) begin errors++; $display("FAIL basic_setup got %0d exp 2", su); end
    checks++; if (per !== 4) begin errors++; $display("FAIL basic_sck_period got %0d exp 4", per); end
    checks++; if (o_nss !== 2'b10) begin errors++; $display("FAIL basic_nss_after got %b exp 10", o_nss); end
  endtask

  task automatic test_reset_mid_xfer();
    logic [7:0] mc, dout; int bc, su, per; bit ab; snap_t sn; exp_t e;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    run_xfer(8'hF0, 8'h0F, 2, ACT_RESET, mc, dout, bc, su, per, ab, sn);
    void'(sb_q.pop_front());
    checks++; if (ab !== 1'b1) begin errors++; $display("FAIL midreset_reached got %b exp 1", ab); end
    checks++; if (sn !== RESET_SNAP) begin errors++; $display("FAIL midreset_outputs got %h exp %h", sn, RESET_SNAP); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(8'hC3, 8'h5A, 2, ACT_NONE, mc, dout, bc, su, per, ab, sn);
    e = sb_q.pop_front();
    checks++; if (mc !== e.tx) begin errors++; $display("FAIL midreset_next_mosi got %h exp %h", mc, e.tx); end
    checks++; if (dout !== e.rx) begin errors++; $display("FAIL midreset_next_dout got %h exp %h", dout, e.rx); end
    checks++; if (bc !== e.busy_cyc) begin errors++; $display("FAIL midreset_next_busy got %0d exp %0d", bc, e.busy_cyc); end
  endtask

  task automatic test_clkdiv1();
    logic [7:0] mc, dout; int bc, su, per; bit ab; snap_t sn; exp_t e;
    sel = 1'b1;
    @(negedge clk);
    run_xfer(8'h00, 8'h81, 1, ACT_NONE, mc, dout, bc, su, per, ab, sn);
    e = sb_q.pop_front();
    checks++; if (dout !== e.rx) begin errors++; $display("FAIL div1_pre_dout got %h exp %h", dout, e.rx); end
    @(negedge clk);
    run_xfer(8'hFF, 8'h00, 1, ACT_NONE, mc, dout, bc, su, per, ab, sn);
    e = sb_q.pop_front();
    checks++; if (mc !== e.tx) begin errors++; $display("FAIL div1_mosi got %h exp %h", mc, e.tx); end
    checks++; if (dout !== e.rx) begin errors++; $display("FAIL div1_dout got %h exp %h", dout, e.rx); end
    checks++; if (bc !== 16) begin errors++; $display("FAIL div1_busy_len got %0d exp 16", bc); end
    checks++; if (per !== 2) begin errors++; $display("FAIL div1_sck_period got %0d exp 2", per); end
    sel = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] mc, dout; int bc, su, per; bit ab; snap_t sn; exp_t e;
    sel = 1'b0;
    csr_write(8'h02);
    run_xfer(8'h5A, 8'h96, 2, ACT_OVR, mc, dout, bc, su, per, ab, sn);
    e = sb_q.pop_front();
    checks++; if (o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", o_ovr); end
    checks++; if (o_nss !== 2'b10) begin errors++; $display("FAIL ovr_nss_kept got %b exp 10", o_nss); end
    checks++; if (mc !== e.tx) begin errors++; $display("FAIL ovr_mosi got %h exp %h", mc, e.tx); end
    checks++; if (dout !== e.rx) begin errors++; $display("FAIL ovr_dout got %h exp %h", dout, e.rx); end
    checks++; if (bc !== e.busy_cyc) begin errors++; $display("FAIL ovr_busy_len got %0d exp %0d", bc, e.busy_cyc); end
    @(negedge clk);
    checks++; if (o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", o_ovr); end
    csr_write(8'h81);
    checks++; if (o_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", o_ovr); end
    checks++; if (o_nss !== 2'b01) begin errors++; $display("FAIL ovr_clear_nss got %b exp 01", o_nss); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mc, dout; int bc, su, per; bit ab; snap_t sn; exp_t e;
    sel = 1'b0;
    @(negedge clk);
    run_xfer(8'h3C, 8'hA5, 2, ACT_NONE, mc, dout, bc, su, per, ab, sn);
    e = sb_q.pop_front();
    checks++; if (dout !== e.rx) begin errors++; $display("FAIL b2b_first_dout got %h exp %h", dout, e.rx); end
    run_xfer(8'h96, 8'h69, 2, ACT_NONE, mc, dout, bc, su, per, ab, sn);
    e = sb_q.pop_front();
    checks++; if (mc !== e.tx) begin errors++; $display("FAIL b2b_second_mosi got %h exp %h", mc, e.tx); end
    checks++; if (dout !== e.rx) begin errors++; $display("FAIL b2b_second_dout got %h exp %h", dout, e.rx); end
    checks++; if (bc !== e.busy_cyc) begin errors++; $display("FAIL b2b_second_busy got %0d exp %0d", bc, e.busy_cyc); end
    checks++; if (su !== 2) begin errors++; $display("FAIL b2b_setup_gap got %0d exp 2", su); end
    checks++; if (o_ovr !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr got %b exp 0", o_ovr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_xfer();
    test_clkdiv1();
    test_overrun();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
